// File: rtl/urv_mtimer.sv
// urv_mtimer: 64-bit machine timer (prescaled mtime, mtimecmp, raw level tick) on a single-cycle register port.
//   clk_i    : core clock
//   rst_n_i  : asynchronous active-low reset
//   addr_i   : register word index (0 CTRL, 1 PRESCALE, 2/3 MTIME, 4/5 CMP, 6 STATUS, 7 reserved)
//   wdata_i  : write data
//   we_i     : write strobe (wins over re_i)
//   re_i     : read strobe
//   rdata_o  : read data, nonzero only with ack_o
//   ack_o    : access acknowledge, one cycle after the strobe
//   tick_o   : registered (mtime >= mtimecmp) level request
module urv_mtimer #(
    parameter int g_prescale_width = 16
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [2:0]  addr_i,
    input  logic [31:0] wdata_i,
    input  logic        we_i,
    input  logic        re_i,
    output logic [31:0] rdata_o,
    output logic        ack_o,
    output logic        tick_o
);
    logic                        en, match_flag, rd, clr, inc, carry, match;
    logic [g_prescale_width-1:0] r, pc, pc_nxt;
    logic [63:0]                 mtime, cmp;
    logic [31:0]                 shadow, lo_nxt, hi_nxt, rd_val;
    logic [7:0]                  wsel;

    assign wsel  = we_i ? 8'd1 << addr_i : 8'd0;
    assign rd    = re_i & ~we_i;
    assign clr   = wsel[0] & wdata_i[1];
    assign inc   = en & (pc >= r);
    // a software write to the low half owns it this cycle, so its old value must not carry
    assign carry = inc & (&mtime[31:0]) & ~wsel[2];
    assign match = mtime >= cmp;

    always_comb begin
        pc_nxt = clr ? '0 : !en ? pc : inc ? '0 : pc + g_prescale_width'(1);
        lo_nxt = clr ? '0 : wsel[2] ? wdata_i : mtime[31:0] + 32'(inc);
        hi_nxt = clr ? '0 : wsel[3] ? wdata_i : mtime[63:32] + 32'(carry);
        rd_val = '0;
        case (addr_i)
            3'd0:    rd_val = {31'd0, en};
            3'd1:    rd_val = 32'(r);
            3'd2:    rd_val = mtime[31:0];
            3'd3:    rd_val = shadow;
            3'd4:    rd_val = cmp[31:0];
            3'd5:    rd_val = cmp[63:32];
            3'd6:    rd_val = {30'd0, match_flag, tick_o};
            default: rd_val = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            en         <= 1'b0;
            r          <= '0;
            pc         <= '0;
            mtime      <= '0;
            shadow     <= '0;
            cmp        <= '1;
            match_flag <= 1'b0;
            tick_o     <= 1'b0;
            ack_o      <= 1'b0;
            rdata_o    <= '0;
        end else begin
            en          <= wsel[0] ? wdata_i[0] : en;
            r           <= wsel[1] ? wdata_i[g_prescale_width-1:0] : r;
            pc          <= pc_nxt;
            mtime       <= {hi_nxt, lo_nxt};
            // low-half read freezes the high half for a tear-free 64-bit read
            shadow      <= (rd && addr_i == 3'd2) ? mtime[63:32] : shadow;
            cmp[31:0]   <= wsel[4] ? wdata_i : cmp[31:0];
            cmp[63:32]  <= wsel[5] ? wdata_i : cmp[63:32];
            match_flag  <= match | (match_flag & ~(wsel[6] & wdata_i[1]));
            tick_o      <= match;
            ack_o       <= we_i | re_i;
            rdata_o     <= rd ? rd_val : '0;
        end
    end
endmodule

// File: tb/tb_urv_mtimer.sv
// tb_urv_mtimer: directed self-checking bench for urv_mtimer.
module tb_urv_mtimer;
    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic [2:0]  addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic        we_i = 1'b0;
    logic        re_i = 1'b0;
    logic [31:0] rdata_o;
    logic        ack_o;
    logic        tick_o;
    int          checks = 0;
    int          failures = 0;
    logic [31:0] v;
    logic [31:0] rst_exp [8] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0};

    urv_mtimer #(.g_prescale_width(16)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .we_i(we_i), .re_i(re_i), .rdata_o(rdata_o), .ack_o(ack_o), .tick_o(tick_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        addr_i = a; wdata_i = d; we_i = 1'b1;
        cyc();
        we_i = 1'b0;
        chk("wr_ack", 32'(ack_o), 32'd1);
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        addr_i = a; re_i = 1'b1;
        cyc();
        re_i = 1'b0;
        chk("rd_ack", 32'(ack_o), 32'd1);
        d = rdata_o;
    endtask

    initial begin
        #1;
        chk("rst_ack", 32'(ack_o), 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        chk("rst_tick", 32'(tick_o), 32'd0);
        cyc(); cyc();
        rst_n_i = 1'b1;
        cyc();
        for (int i = 0; i < 8; i++) begin
            rd(3'(i), v);
            chk($sformatf("rst_reg%0d", i), v, rst_exp[i]);
            chk("rst_reg_tick", 32'(tick_o), 32'd0);
        end
        cyc();
        chk("idle_ack", 32'(ack_o), 32'd0);
        chk("idle_rdata", rdata_o, 32'd0);

        // prescale R=3, CMP=5: mtime reaches 5 at the 20th enabled edge
        wr(3'd1, 32'd3);
        wr(3'd5, 32'hFFFF_FFFF);
        wr(3'd4, 32'd5);
        wr(3'd5, 32'd0);
        wr(3'd0, 32'd1);
        repeat (19) cyc();
        rd(3'd2, v); chk("ps_mtime19", v, 32'd4);
        chk("ps_tick_before", 32'(tick_o), 32'd0);
        rd(3'd2, v); chk("ps_mtime20", v, 32'd5);
        chk("ps_tick_rise", 32'(tick_o), 32'd1);
        rd(3'd6, v); chk("ps_status", v, 32'd3);

        // atomic 64-bit read across a carry
        wr(3'd0, 32'd2);
        wr(3'd1, 32'd0);
        wr(3'd3, 32'd0);
        wr(3'd2, 32'hFFFF_FFFF);
        wr(3'd0, 32'd1);
        rd(3'd2, v); chk("atom_lo0", v, 32'hFFFF_FFFF);
        rd(3'd3, v); chk("atom_hi0", v, 32'd0);
        rd(3'd2, v); chk("atom_lo1", v, 32'd1);
        rd(3'd3, v); chk("atom_hi1", v, 32'd1);

        // wrap-around from 2^64-2 with CMP = 2^64-1
        wr(3'd0, 32'd0);
        wr(3'd5, 32'hFFFF_FFFF);
        wr(3'd4, 32'hFFFF_FFFF);
        wr(3'd3, 32'hFFFF_FFFF);
        wr(3'd2, 32'hFFFF_FFFE);
        wr(3'd6, 32'd2);
        rd(3'd6, v); chk("wrap_status0", v, 32'd0);
        wr(3'd0, 32'd1);
        chk("wrap_tick_e0", 32'(tick_o), 32'd0);
        cyc(); chk("wrap_tick_e1", 32'(tick_o), 32'd0);
        cyc(); chk("wrap_tick_e2", 32'(tick_o), 32'd1);
        cyc(); chk("wrap_tick_e3", 32'(tick_o), 32'd0);
        rd(3'd6, v); chk("wrap_match_sticky", v, 32'd2);
        wr(3'd6, 32'd2);
        rd(3'd6, v); chk("wrap_match_clr", v, 32'd0);
        rd(3'd2, v); chk("wrap_lo", v, 32'd4);
        rd(3'd3, v); chk("wrap_hi", v, 32'd0);

        // collisions
        wr(3'd0, 32'd3);
        rd(3'd2, v); chk("clr_zero", v, 32'd0);
        rd(3'd2, v); chk("clr_resume", v, 32'd1);
        wr(3'd3, 32'd0);
        wr(3'd2, 32'h100);
        rd(3'd2, v); chk("lo_wr_wins", v, 32'h100);
        wr(3'd2, 32'hFFFF_FFFF);
        wr(3'd2, 32'd5);
        rd(3'd2, v); chk("nocarry_lo", v, 32'd5);
        rd(3'd3, v); chk("nocarry_hi", v, 32'd0);
        wr(3'd4, 32'd0);
        wr(3'd5, 32'd0);
        wr(3'd6, 32'd2);
        rd(3'd6, v); chk("set_beats_clr", v, 32'd3);

        // compare re-arm
        wr(3'd5, 32'hFFFF_FFFF);
        chk("rearm_tick_hold", 32'(tick_o), 32'd1);
        cyc(); chk("rearm_tick_drop", 32'(tick_o), 32'd0);
        wr(3'd0, 32'd2);
        wr(3'd4, 32'd10);
        wr(3'd5, 32'd0);
        wr(3'd0, 32'd1);
        repeat (10) cyc();
        chk("rearm_tick_early", 32'(tick_o), 32'd0);
        cyc(); chk("rearm_tick_rise", 32'(tick_o), 32'd1);

        // reset during a pending read
        addr_i = 3'd2; re_i = 1'b1;
        #2 rst_n_i = 1'b0;
        cyc();
        re_i = 1'b0;
        chk("abort_ack", 32'(ack_o), 32'd0);
        chk("abort_rdata", rdata_o, 32'd0);
        chk("abort_tick", 32'(tick_o), 32'd0);
        rst_n_i = 1'b1;
        cyc();
        rd(3'd2, v); chk("abort_mtime", v, 32'd0);
        rd(3'd5, v); chk("abort_cmp_hi", v, 32'hFFFF_FFFF);
        rd(3'd0, v); chk("abort_ctrl", v, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
